// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer feeding the decoder, with MIPS delay-slot redirect.
// Latency: fetch takes 1 cycle plus memory wait cycles; inst_valid rises the cycle after the read completes.
// Backpressure: memory stalls via waitrequest hold read/address; the control block holds EXEC by withholding endi.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        endi,
    input  logic        branchtrue,
    input  logic        jumptrue,
    input  logic        jrtrue,
    input  logic [31:0] jr_target,
    output logic [31:0] address,
    output logic        read,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] link_addr,
    output logic        active
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] target;
    logic [31:0] nxt_pc;
    logic        taken;

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        branch_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
        taken      = jrtrue | jumptrue | branchtrue;

        // JR wins over J, which wins over a conditional branch
        if (jrtrue) begin
            target = jr_target & 32'hFFFF_FFFC;
        end else if (jumptrue) begin
            target = {pc_plus4[31:28], inst_q[25:0], 2'b00};
        end else begin
            target = pc_plus4 + branch_off;
        end

        if (pend_valid_q) begin
            nxt_pc = pend_target_q;
        end else begin
            nxt_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        case (state_q)
            FETCH: begin
                if (!waitrequest) begin
                    inst_d  = readdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (endi) begin
                    pc_d         = nxt_pc;
                    pend_valid_d = taken;
                    if (taken) begin
                        pend_target_d = target;
                    end
                    state_d = (nxt_pc == 32'd0) ? HALT : FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_VECTOR;
            inst_q        <= 32'd0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // reset gates the request combinationally so an in-flight read is abandoned that same cycle
    assign address    = pc_q;
    assign read       = (state_q == FETCH) && !reset;
    assign inst       = inst_q;
    assign inst_valid = (state_q == EXEC) && !reset;
    assign link_addr  = pc_q + 32'd8;
    assign active     = reset || (state_q != HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetch addresses are queued as endi is driven
// and popped as each fetch completes on the bus.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV  = 32'hBFC0_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        waitrequest = 1'b1;
    logic [31:0] readdata = 32'd0;
    logic        endi = 1'b0;
    logic        branchtrue = 1'b0;
    logic        jumptrue = 1'b0;
    logic        jrtrue = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] address;
    logic        read;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] link_addr;
    logic        active;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_pc, m_inst, m_pend_t;
    logic        m_pend_v, m_halt;

    pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .readdata(readdata),
        .endi(endi), .branchtrue(branchtrue), .jumptrue(jumptrue), .jrtrue(jrtrue),
        .jr_target(jr_target), .address(address), .read(read), .inst(inst),
        .inst_valid(inst_valid), .link_addr(link_addr), .active(active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_ctl();
        endi = 1'b0; branchtrue = 1'b0; jumptrue = 1'b0; jrtrue = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc = RV; m_inst = 32'd0; m_pend_v = 1'b0; m_pend_t = 32'd0; m_halt = 1'b0;
        exp_q.push_back(RV);
    endtask

    // Called just after a rising edge; reset is seen by the DUT at the following edge.
    task automatic apply_reset();
        reset = 1'b1; waitrequest = 1'b1; clear_ctl();
        @(negedge clk);
        check_eq("rst_read", read, 1'b0);
        check_eq("rst_inst_valid", inst_valid, 1'b0);
        check_eq("rst_active", active, 1'b1);
        @(posedge clk); #1;
        check_eq("rst_address", address, RV);
        check_eq("rst_inst", inst, 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_fetch(input logic [31:0] data, input int waits);
        logic [31:0] want;
        if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL fetch_underflow: got no expected address required one");
            want = 32'hDEAD_BEEF;
        end else begin
            want = exp_q.pop_front();
        end
        m_pc = want;
        // control inputs asserted during FETCH must be ignored
        waitrequest = 1'b1; endi = 1'b1; jumptrue = 1'b1; branchtrue = 1'b1;
        for (int i = 0; i < waits; i++) begin
            readdata = $urandom;
            @(negedge clk);
            check_eq("stall_read", read, 1'b1);
            check_eq("stall_addr", address, want);
            check_eq("stall_inst_valid", inst_valid, 1'b0);
            @(posedge clk); #1;
        end
        waitrequest = 1'b0; readdata = data;
        @(negedge clk);
        check_eq("fetch_read", read, 1'b1);
        check_eq("fetch_addr", address, want);
        @(posedge clk); #1;
        waitrequest = 1'b1; readdata = $urandom; clear_ctl();
        m_inst = data;
        check_eq("inst_latched", inst, data);
        check_eq("inst_valid_up", inst_valid, 1'b1);
    endtask

    task automatic do_exec(input int delay, input logic br, input logic j, input logic jr,
                           input logic [31:0] jrt);
        logic [31:0] pc4, tgt, nxt;
        logic        taken;
        // flags outside the endi cycle must not be sampled
        branchtrue = 1'b1; jumptrue = 1'b1; jrtrue = 1'b1; jr_target = $urandom; endi = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check_eq("exec_hold_valid", inst_valid, 1'b1);
            check_eq("exec_hold_read", read, 1'b0);
            check_eq("exec_hold_inst", inst, m_inst);
            check_eq("exec_hold_link", link_addr, m_pc + 32'd8);
            @(posedge clk); #1;
        end
        endi = 1'b1; branchtrue = br; jumptrue = j; jrtrue = jr; jr_target = jrt;
        @(negedge clk);
        check_eq("exec_valid", inst_valid, 1'b1);
        check_eq("exec_read", read, 1'b0);
        check_eq("exec_link", link_addr, m_pc + 32'd8);
        check_eq("exec_active", active, 1'b1);
        @(posedge clk); #1;
        clear_ctl(); jr_target = $urandom;

        pc4   = m_pc + 32'd4;
        taken = br | j | jr;
        if (jr)     tgt = {jrt[31:2], 2'b00};
        else if (j) tgt = {pc4[31:28], m_inst[25:0], 2'b00};
        else        tgt = pc4 + {{14{m_inst[15]}}, m_inst[15:0], 2'b00};
        nxt = m_pend_v ? m_pend_t : pc4;
        if (taken) m_pend_t = tgt;
        m_pend_v = taken;
        if (nxt == 32'd0) m_halt = 1'b1;
        else              exp_q.push_back(nxt);
    endtask

    task automatic halt_check();
        for (int i = 0; i < 10; i++) begin
            endi = 1'b1; jumptrue = 1'b1; jr_target = 32'h1234_5678;
            @(negedge clk);
            check_eq("halt_read", read, 1'b0);
            check_eq("halt_active", active, 1'b0);
            check_eq("halt_inst_valid", inst_valid, 1'b0);
            @(posedge clk); #1;
        end
        clear_ctl();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        apply_reset();

        // wait states on the first fetch, then straight-line code
        do_fetch(NOP, 3);            do_exec(0, 0, 0, 0, 0);
        do_fetch(NOP, 0);            do_exec(0, 0, 0, 0, 0);
        do_fetch(NOP, 0);            do_exec(2, 0, 0, 0, 0);
        do_fetch(NOP, 1);            do_exec(0, 0, 0, 0, 0);

        // BFC00010: backwards branch, delay slot at BFC00014, lands on BFC00004
        do_fetch(32'h1000_FFFC, 0);  do_exec(0, 1, 0, 0, 0);
        do_fetch(NOP, 0);            do_exec(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            do_fetch(NOP, 0);        do_exec(0, 0, 0, 0, 0);
        end

        // BFC00020: J and JR together, JR target BFC00103 wins and is word-aligned
        do_fetch(32'h0800_0100, 0);  do_exec(0, 0, 1, 1, 32'hBFC0_0103);
        do_fetch(NOP, 0);            do_exec(1, 0, 0, 0, 0);

        // BFC00100: branch whose delay slot is itself a taken branch
        do_fetch(32'h1000_0004, 0);  do_exec(0, 1, 0, 0, 0);
        do_fetch(32'h1000_0002, 0);  do_exec(0, 1, 0, 0, 0);
        do_fetch(NOP, 0);            do_exec(0, 0, 0, 0, 0);

        // JR to 0: delay slot still fetched, then halt
        do_fetch(NOP, 0);            do_exec(0, 0, 0, 1, 32'h0000_0000);
        do_fetch(NOP, 0);            do_exec(0, 0, 0, 0, 0);
        halt_check();

        apply_reset();
        // set up a pending redirect, then reset while the delay-slot fetch is stalled
        do_fetch(32'h1000_0010, 0);  do_exec(0, 1, 0, 0, 0);
        waitrequest = 1'b1;
        @(negedge clk);
        check_eq("midstall_read", read, 1'b1);
        check_eq("midstall_addr", address, RV + 32'd4);
        @(posedge clk); #1;
        apply_reset();
        do_fetch(NOP, 0);            do_exec(0, 0, 0, 0, 0);
        do_fetch(NOP, 0);            do_exec(0, 0, 0, 0, 0);
        do_fetch(NOP, 2);            do_exec(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
